// File: rtl/rob_pkg.sv
// Shared types and constants for the multi-commit reorder buffer.
// Entry storage is sized for the widest supported XLEN; narrower builds zero-extend.
package rob_pkg;
  localparam int         ROB_XLEN     = 32;
  localparam logic [4:0] ROB_DST_NONE = 5'd0;
  localparam int         COMMIT_W_MAX = 2;

  typedef struct packed {
    logic                busy;
    logic                ready;
    logic [4:0]          dst;
    logic                branch;
    logic                store;
    logic [ROB_XLEN-1:0] pc;
    logic                pred_taken;
    logic [ROB_XLEN-1:0] pred_target;
    logic [ROB_XLEN-1:0] value;
    logic [ROB_XLEN-1:0] store_data;
    logic                taken;
    logic [ROB_XLEN-1:0] target;
  } rob_entry_t;

  typedef struct packed {
    logic                valid;
    logic [4:0]          dst;
    logic                store;
    logic [ROB_XLEN-1:0] value;
    logic [ROB_XLEN-1:0] addr;
  } rob_commit_t;
endpackage

// File: rtl/rob_commit_select.sv
// Picks which of the two oldest entries retire this cycle and builds their commit
// records; also detects a mispredicted branch at the head and computes the redirect PC.
module rob_commit_select
  import rob_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int COMMIT_W = 2
) (
  input  logic                commit_ready_i,
  input  rob_entry_t          e0_i,
  input  logic                e1_busy_i,
  input  logic                e1_ready_i,
  input  logic                e1_branch_i,
  input  logic                e1_store_i,
  input  logic [4:0]          e1_dst_i,
  input  logic [ROB_XLEN-1:0] e1_value_i,
  input  logic [ROB_XLEN-1:0] e1_store_data_i,
  output rob_commit_t         c0_o,
  output rob_commit_t         c1_o,
  output logic                mispredict_o,
  output logic [XLEN-1:0]     redirect_pc_o
);
  logic            ret0, ret1;
  logic [XLEN-1:0] tgt, ptgt, pc;

  assign tgt  = XLEN'(e0_i.target);
  assign ptgt = XLEN'(e0_i.pred_target);
  assign pc   = XLEN'(e0_i.pc);

  always_comb begin
    ret0 = commit_ready_i && e0_i.busy && e0_i.ready;
    // Branches retire alone so a flush never races a younger commit; one store port.
    ret1 = (COMMIT_W == COMMIT_W_MAX) && ret0 && e1_busy_i && e1_ready_i &&
           !e0_i.branch && !e1_branch_i && !(e0_i.store && e1_store_i);
    c0_o = '0;
    c1_o = '0;
    if (ret0) begin
      c0_o.valid = 1'b1;
      c0_o.store = e0_i.store;
      c0_o.dst   = e0_i.branch ? ROB_DST_NONE : e0_i.dst;
      c0_o.value = e0_i.store ? e0_i.store_data : e0_i.value;
      c0_o.addr  = e0_i.store ? e0_i.value : '0;
    end
    if (ret1) begin
      c1_o.valid = 1'b1;
      c1_o.store = e1_store_i;
      c1_o.dst   = e1_dst_i;
      c1_o.value = e1_store_i ? e1_store_data_i : e1_value_i;
      c1_o.addr  = e1_store_i ? e1_value_i : '0;
    end
    mispredict_o  = ret0 && e0_i.branch &&
                    ((e0_i.taken != e0_i.pred_taken) || (e0_i.taken && (tgt != ptgt)));
    redirect_pc_o = '0;
    if (mispredict_o) redirect_pc_o = e0_i.taken ? tgt : pc + XLEN'(4);
  end
endmodule

// File: rtl/reorder_buffer_mc.sv
// Parametrised reorder buffer: in-order allocate, CDB capture with operand bypass,
// up to COMMIT_W retires per cycle, and mispredict flush at branch commit.
module reorder_buffer_mc
  import rob_pkg::*;
#(
  parameter  int DEPTH    = 16,
  parameter  int XLEN     = 32,
  parameter  int COMMIT_W = 2,
  localparam int TAG_W    = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [4:0]               issue_dst_i,
  input  logic                     issue_branch_i,
  input  logic                     issue_store_i,
  input  logic [XLEN-1:0]          issue_pc_i,
  input  logic                     issue_pred_taken_i,
  input  logic [XLEN-1:0]          issue_pred_target_i,
  output logic [TAG_W-1:0]         issue_tag_o,
  input  logic                     cdb_valid_i,
  input  logic [TAG_W-1:0]         cdb_tag_i,
  input  logic [XLEN-1:0]          cdb_data_i,
  input  logic [XLEN-1:0]          cdb_store_data_i,
  input  logic                     cdb_br_taken_i,
  input  logic [XLEN-1:0]          cdb_br_target_i,
  input  logic [TAG_W-1:0]         src1_tag_i,
  input  logic [TAG_W-1:0]         src2_tag_i,
  output logic [XLEN-1:0]          src1_value_o,
  output logic [XLEN-1:0]          src2_value_o,
  output logic                     src1_ready_o,
  output logic                     src2_ready_o,
  input  logic                     commit_ready_i,
  output logic [COMMIT_W-1:0]      commit_valid_o,
  output logic [COMMIT_W*TAG_W-1:0] commit_tag_o,
  output logic [COMMIT_W*5-1:0]    commit_dst_o,
  output logic [COMMIT_W*XLEN-1:0] commit_value_o,
  output logic [COMMIT_W*XLEN-1:0] commit_addr_o,
  output logic [COMMIT_W-1:0]      commit_store_o,
  output logic                     flush_o,
  output logic [XLEN-1:0]          flush_pc_o,
  output logic [TAG_W:0]           count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam logic [TAG_W:0] PTR_ONE = (TAG_W+1)'(1);
  localparam logic [TAG_W:0] CNT_MAX = (TAG_W+1)'(DEPTH);

  rob_entry_t         ent_q [DEPTH];
  rob_entry_t         ent_d [DEPTH];
  logic [TAG_W:0]     head_q, head_d, tail_q, tail_d, count_q, count_d;
  rob_commit_t        cm_q [COMMIT_W];
  rob_commit_t        cm_d [COMMIT_W];
  logic [TAG_W-1:0]   ctag_q [COMMIT_W];
  logic [TAG_W-1:0]   ctag_d [COMMIT_W];
  logic               flush_q;
  logic [XLEN-1:0]    fpc_q;
  logic [TAG_W-1:0]   hidx, hidx1, tidx;
  rob_commit_t        sel_c [COMMIT_W_MAX];
  rob_commit_t        c0, c1;
  logic               mispredict, issue_fire, hit1, hit2;
  logic [XLEN-1:0]    redirect_pc;
  logic [TAG_W:0]     n_ret, n_iss;

  assign hidx  = head_q[TAG_W-1:0];
  assign hidx1 = hidx + TAG_W'(1);
  assign tidx  = tail_q[TAG_W-1:0];

  rob_commit_select #(.XLEN(XLEN), .COMMIT_W(COMMIT_W)) u_sel (
    .commit_ready_i  (commit_ready_i),
    .e0_i            (ent_q[hidx]),
    .e1_busy_i       (ent_q[hidx1].busy),
    .e1_ready_i      (ent_q[hidx1].ready),
    .e1_branch_i     (ent_q[hidx1].branch),
    .e1_store_i      (ent_q[hidx1].store),
    .e1_dst_i        (ent_q[hidx1].dst),
    .e1_value_i      (ent_q[hidx1].value),
    .e1_store_data_i (ent_q[hidx1].store_data),
    .c0_o            (c0),
    .c1_o            (c1),
    .mispredict_o    (mispredict),
    .redirect_pc_o   (redirect_pc)
  );
  assign sel_c[0] = c0;
  assign sel_c[1] = c1;

  assign issue_ready_o = (count_q != CNT_MAX) && !flush_q;
  assign issue_fire    = issue_valid_i && issue_ready_o;
  assign issue_tag_o   = tidx;
  assign count_o       = count_q;
  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == CNT_MAX);
  assign flush_o       = flush_q;
  assign flush_pc_o    = fpc_q;
  assign n_ret         = (TAG_W+1)'(c0.valid) + (TAG_W+1)'(c1.valid);
  assign n_iss         = (TAG_W+1)'(issue_fire);

  // Same-cycle CDB result wins over the stored copy.
  assign hit1         = cdb_valid_i && (cdb_tag_i == src1_tag_i);
  assign hit2         = cdb_valid_i && (cdb_tag_i == src2_tag_i);
  assign src1_value_o = hit1 ? cdb_data_i : XLEN'(ent_q[src1_tag_i].value);
  assign src2_value_o = hit2 ? cdb_data_i : XLEN'(ent_q[src2_tag_i].value);
  assign src1_ready_o = hit1 || (ent_q[src1_tag_i].busy && ent_q[src1_tag_i].ready);
  assign src2_ready_o = hit2 || (ent_q[src2_tag_i].busy && ent_q[src2_tag_i].ready);

  for (genvar s = 0; s < COMMIT_W; s++) begin : g_out
    assign commit_valid_o[s]               = cm_q[s].valid;
    assign commit_store_o[s]               = cm_q[s].store;
    assign commit_tag_o[s*TAG_W +: TAG_W]  = ctag_q[s];
    assign commit_dst_o[s*5 +: 5]          = cm_q[s].dst;
    assign commit_value_o[s*XLEN +: XLEN]  = XLEN'(cm_q[s].value);
    assign commit_addr_o[s*XLEN +: XLEN]   = XLEN'(cm_q[s].addr);
  end

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int s = 0; s < COMMIT_W; s++) begin
      cm_d[s]   = sel_c[s];
      ctag_d[s] = sel_c[s].valid ? hidx + TAG_W'(s) : '0;
    end
    if (mispredict) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (issue_fire) begin
        ent_d[tidx]             = '0;
        ent_d[tidx].busy        = 1'b1;
        ent_d[tidx].dst         = issue_dst_i;
        ent_d[tidx].branch      = issue_branch_i;
        ent_d[tidx].store       = issue_store_i;
        ent_d[tidx].pc          = ROB_XLEN'(issue_pc_i);
        ent_d[tidx].pred_taken  = issue_pred_taken_i;
        ent_d[tidx].pred_target = ROB_XLEN'(issue_pred_target_i);
        tail_d                  = tail_q + PTR_ONE;
      end
      if (cdb_valid_i && ent_q[cdb_tag_i].busy) begin
        ent_d[cdb_tag_i].ready      = 1'b1;
        ent_d[cdb_tag_i].value      = ROB_XLEN'(cdb_data_i);
        ent_d[cdb_tag_i].store_data = ROB_XLEN'(cdb_store_data_i);
        ent_d[cdb_tag_i].taken      = cdb_br_taken_i;
        ent_d[cdb_tag_i].target     = ROB_XLEN'(cdb_br_target_i);
      end
      if (c0.valid) ent_d[hidx].busy  = 1'b0;
      if (c1.valid) ent_d[hidx1].busy = 1'b0;
      head_d  = head_q + n_ret;
      count_d = count_q + n_iss - n_ret;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      for (int s = 0; s < COMMIT_W; s++) begin
        cm_q[s]   <= '0;
        ctag_q[s] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      flush_q <= 1'b0;
      fpc_q   <= '0;
    end else begin
      ent_q   <= ent_d;
      cm_q    <= cm_d;
      ctag_q  <= ctag_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      flush_q <= mispredict;
      fpc_q   <= redirect_pc;
    end
  end
endmodule

// File: doc/reorder_buffer_mc.md
Name: reorder_buffer_mc

Overview:
Parametrised reorder buffer that succeeds the fixed 16-entry, single-commit ROB. Sits between issue and the register file / store unit of the Tomasulo core.
- Allocates entries in program order and captures CDB results.
- Forwards operands to issue, including same-cycle CDB bypass.
- Retires up to COMMIT_W entries per cycle under back-pressure.
- Detects branch mispredicts (direction and target) at commit and issues a flush.

Parameters:
DEPTH, 16, entry count; power of two, 4..64
XLEN, 32, data/address width
COMMIT_W, 2, commit slots per cycle; 1 or 2
TAG_W, $clog2(DEPTH), derived ROB tag width; not overridden

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  asynchronous, active-high reset
issue_valid_i  in  1  allocate request
issue_ready_o  out  1  high when count<DEPTH and flush_o low
issue_dst_i  in  5  architectural destination; 0 = no write
issue_branch_i  in  1  entry is a conditional branch
issue_store_i  in  1  entry is a store
issue_pc_i  in  XLEN  instruction PC
issue_pred_taken_i  in  1  predicted direction
issue_pred_target_i  in  XLEN  predicted target
issue_tag_o  out  TAG_W  tag allocated on this handshake (= tail index)
cdb_valid_i  in  1  result broadcast
cdb_tag_i  in  TAG_W  producing entry
cdb_data_i  in  XLEN  result; store address for stores
cdb_store_data_i  in  XLEN  store data
cdb_br_taken_i  in  1  resolved direction (branches)
cdb_br_target_i  in  XLEN  resolved target (branches)
src1_tag_i, src2_tag_i  in  TAG_W  operand lookup tags
src1_value_o, src2_value_o  out  XLEN  operand value
src1_ready_o, src2_ready_o  out  1  value valid
commit_ready_i  in  1  consumer can accept a commit this cycle
commit_valid_o  out  COMMIT_W  per-slot retire strobe
commit_tag_o  out  COMMIT_W*TAG_W  per-slot tag
commit_dst_o  out  COMMIT_W*5  per-slot destination
commit_value_o  out  COMMIT_W*XLEN  result, or store data for stores
commit_addr_o  out  COMMIT_W*XLEN  store address; 0 otherwise
commit_store_o  out  COMMIT_W  per-slot store flag
flush_o  out  1  one-cycle mispredict flush pulse
flush_pc_o  out  XLEN  redirect PC
count_o  out  TAG_W+1  occupancy
empty_o, full_o  out  1  count==0 / count==DEPTH

Behaviour:
- Reset: all entries invalid; head=tail=0; count=0; every registered output 0; empty_o=1. Async assert mid-operation discards all in-flight state; no commit or flush is emitted.
- Pointers: TAG_W+1 bits including a wrap bit; index = low TAG_W bits. Full/empty come from count, not pointer compare. Wrap DEPTH-1→0 is seamless.
- Issue: the handshake is issue_valid_i && issue_ready_o.
  - issue_ready_o uses start-of-cycle count. A slot freed by commit is reusable next cycle, not the same cycle.
  - The entry is written busy=1, ready=0, value=0.
- CDB write: accepted only if the target entry is busy; otherwise ignored. Sets ready=1 and captures data, store data, taken and target. A late CDB to an entry flushed this cycle is dropped.
- Operand read (combinational): when cdb_valid_i && cdb_tag_i==srcN_tag_i, output cdb_data_i with ready=1. Otherwise output the entry's value, with ready = busy&&ready.
- Commit decision (combinational; results registered, 1-cycle latency):
  - Nothing retires while commit_ready_i=0.
  - slot0 = head if busy&&ready.
  - slot1 (COMMIT_W=2) = head+1 if slot0 retires, that entry is busy&&ready, neither entry is a branch, and at most one of the two is a store.
  - Retired entries clear busy. head advances by the number retired. count = count + issued - retired.
- Branch commit (always slot0 only):
  - mispredict = (taken != pred_taken) || (taken && target != pred_target).
  - commit_valid_o[0]=1 with dst=0.
  - On mispredict, at that same edge: flush_o=1; flush_pc_o = taken ? target : pc+4; all entries invalidated; head=tail=count=0; any same-cycle issue is discarded.
  - issue_ready_o=0 while flush_o=1.
- Outputs are zeroed in every cycle with no retire or flush. flush_pc_o=0 when flush_o=0.

Decomposition:
- Package rob_pkg holds:
  - rob_entry_t (busy, ready, dst, branch, store, pc, pred_taken, pred_target, value, store_data, taken, target)
  - rob_commit_t
  - constants ROB_DST_NONE=5'd0 and COMMIT_W_MAX=2
- Sub-module rob_commit_select: combinational slot selection plus mispredict detect and redirect PC computation.

Test Plan:
- Reset, then issue 16 entries with no CDB → tags 0..15; full_o=1 and issue_ready_o=0 after the 16th; a 17th request is not accepted; count_o=16.
- Issue tags 0,1 (dst 3,4); CDB tag1=0x22 then tag0=0x11 → next cycle after tag0 arrives, commit_valid_o=2'b11 with dst 3/4 and values 0x11/0x22; count_o=0.
- Branch at tag 0 (pc 0x100, pred not-taken), 3 younger entries; CDB taken, target 0x200 → one cycle after commit, flush_o=1, flush_pc_o=0x200, count_o=0; same-cycle issue_valid_i ignored.
- Branch predicted taken to 0x180, resolved taken to 0x1C0 → flush_pc_o=0x1C0. Correct prediction → no flush, commit of dst 0.
- Two adjacent ready stores → committed in consecutive cycles, one per cycle; commit_addr_o/commit_value_o = CDB data/store data.
- Hold commit_ready_i=0 for 3 cycles with head ready → no commit_valid_o. Wrap test: 40 issue/commit cycles at DEPTH=16 → tags wrap 15→0 with count ≤16; src lookup on a CDB tag returns cdb_data_i with ready=1 in the same cycle.
